ahb_lite_decoder_mux: RTL and testbench



---
 rtl/ahb_lite_decoder_mux.sv | 143 ++++++++++++++
 tb/tb_ahb_lite_decoder_mux.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-lite address decoder and slave-to-master response multiplexer.
// Slave i owns HADDR[31:28] == i; everything above NUM_SLAVES-1 goes to a
// built-in default slave that answers valid transfers with a two-cycle ERROR.
module ahb_lite_decoder_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  output logic [NUM_SLAVES-1:0]   HSEL,
  input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]   HREADYOUT_S,
  input  logic [2*NUM_SLAVES-1:0] HRESP_S,
  output logic                    HREADY,
  output logic [1:0]              HRESP,
  output logic [31:0]             HRDATA,
  output logic [CNT_W-1:0]        ERR_CNT
);

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  localparam logic [4:0] NS = 5'(NUM_SLAVES);

  logic [3:0] region;
  logic       dflt_sel;
  logic       dvalid;
  logic       unused_addr;

  // Data-phase target: slave index, default-slave flag, nothing-selected flag
  logic [3:0] sel_idx_q, sel_idx_d;
  logic       sel_dflt_q, sel_dflt_d;
  logic       sel_none_q, sel_none_d;

  ds_state_t  state_q, state_d;
  logic       ds_ready;
  logic [1:0] ds_resp;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign region      = HADDR[31:28];
  assign dflt_sel    = ({1'b0, region} >= NS);
  assign dvalid      = dflt_sel & HTRANS[1] & HREADY;
  assign unused_addr = ^{HADDR[27:0], HTRANS[0]};
  assign ERR_CNT     = err_cnt_q;

  // Address-phase one-hot decode; unmapped regions leave HSEL all zero
  always_comb begin
    HSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (region == 4'(i)) HSEL[i] = 1'b1;
    end
  end

  // Capture the decoded target only when the bus advances
  always_comb begin
    sel_idx_d  = sel_idx_q;
    sel_dflt_d = sel_dflt_q;
    sel_none_d = sel_none_q;
    if (HREADY) begin
      sel_none_d = 1'b0;
      sel_dflt_d = dflt_sel;
      sel_idx_d  = dflt_sel ? 4'd0 : region;
    end
  end

  // Data-phase select register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_idx_q  <= 4'd0;
      sel_dflt_q <= 1'b0;
      sel_none_q <= 1'b1;
    end else begin
      sel_idx_q  <= sel_idx_d;
      sel_dflt_q <= sel_dflt_d;
      sel_none_q <= sel_none_d;
    end
  end

  // Default-slave outputs depend on state only, keeping HREADY free of loops
  always_comb begin
    ds_ready = 1'b1;
    ds_resp  = 2'b00;
    case (state_q)
      DS_ERR1: begin ds_ready = 1'b0; ds_resp = 2'b01; end
      DS_ERR2: begin ds_ready = 1'b1; ds_resp = 2'b01; end
      default: begin ds_ready = 1'b1; ds_resp = 2'b00; end
    endcase
  end

  // Default-slave next state; ERR2 may chain straight into another ERR1
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: state_d = dvalid ? DS_ERR1 : DS_IDLE;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = dvalid ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // Count every entry into the first error cycle, saturating at all-ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_d == DS_ERR1) err_cnt_d = sat_inc(err_cnt_q);
  end

  // FSM state and error counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= DS_IDLE;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Response mux; the loop compares against real slave indices only
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 2'b00;
    HRDATA = '0;
    if (sel_dflt_q) begin
      HREADY = ds_ready;
      HRESP  = ds_resp;
    end else if (!sel_none_q) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_idx_q == 4'(i)) begin
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[2*i +: 2];
          HRDATA = HRDATA_S[32*i +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Self-checking bench for ahb_lite_decoder_mux: directed table, hand-written
// wait-state / saturation / reset sequences, and randomized traffic against
// a transaction-level reference model.
module tb_ahb_lite_decoder_mux;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [31:0]  HADDR = '0;
  logic [1:0]   HTRANS = '0;
  logic [3:0]   HSEL;
  logic [127:0] HRDATA_S = '0;
  logic [3:0]   HREADYOUT_S = 4'hF;
  logic [7:0]   HRESP_S = '0;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [31:0]  HRDATA;
  logic [7:0]   ERR_CNT;

  int errors = 0;
  int checks = 0;

  // Reference model: what is in the data phase, and how many error cycles
  // the default slave still owes (2 = first, 1 = second, 0 = none).
  int m_kind = 0;   // 0 nothing, 1 mapped slave, 2 default slave
  int m_idx  = 0;
  int m_left = 0;
  int m_cnt  = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  hsel;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [12];

  ahb_lite_decoder_mux #(.NUM_SLAVES(4), .CNT_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL(HSEL), .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S(HRESP_S), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .ERR_CNT(ERR_CNT)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_hsel();
    int r;
    r = int'(HADDR[31:28]);
    return (r < 4) ? 4'(1 << r) : 4'b0000;
  endfunction

  function automatic logic exp_ready();
    if (m_kind == 1) return HREADYOUT_S[m_idx];
    if (m_kind == 2) return (m_left != 2);
    return 1'b1;
  endfunction

  function automatic logic [1:0] exp_resp();
    if (m_kind == 1) return HRESP_S[2*m_idx +: 2];
    if (m_kind == 2) return (m_left != 0) ? 2'b01 : 2'b00;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_data();
    if (m_kind == 1) return HRDATA_S[32*m_idx +: 32];
    return 32'h0;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " HSEL"},    32'(HSEL),    32'(exp_hsel()));
    chk({tag, " HREADY"},  32'(HREADY),  32'(exp_ready()));
    chk({tag, " HRESP"},   32'(HRESP),   32'(exp_resp()));
    chk({tag, " HRDATA"},  HRDATA,       exp_data());
    chk({tag, " ERR_CNT"}, 32'(ERR_CNT), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_kind = 0; m_idx = 0; m_left = 0; m_cnt = 0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    HADDR  = a;
    HTRANS = t;
    #1;
  endtask

  // Advance one clock and step the model with the values seen at the edge
  task automatic tick();
    logic        r;
    logic [31:0] a;
    logic [1:0]  t;
    int          rg;
    r = exp_ready();
    a = HADDR;
    t = HTRANS;
    @(posedge HCLK);
    if (m_kind == 2 && m_left == 2) begin
      m_left = 1;
    end else if (r) begin
      rg = int'(a[31:28]);
      if (rg < 4) begin
        m_kind = 1; m_idx = rg; m_left = 0;
      end else begin
        m_kind = 2;
        m_left = t[1] ? 2 : 0;
        if (t[1] && m_cnt < 255) m_cnt++;
      end
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " HREADY"},  32'(HREADY),  32'h1);
    chk({tag, " HRESP"},   32'(HRESP),   32'h0);
    chk({tag, " HRDATA"},  HRDATA,       32'h0);
    chk({tag, " ERR_CNT"}, 32'(ERR_CNT), 32'h0);
  endtask

  initial begin
    int lows;

    tbl[0]  = '{32'h0000_0000, 2'b00, 4'b0001, 1'b1, 2'b00, 32'h0,         8'd0};
    tbl[1]  = '{32'h1000_0004, 2'b10, 4'b0010, 1'b1, 2'b00, 32'hA5A5_0000, 8'd0};
    tbl[2]  = '{32'h7000_0000, 2'b10, 4'b0000, 1'b1, 2'b00, 32'hA5A5_0001, 8'd0};
    tbl[3]  = '{32'h7000_0000, 2'b00, 4'b0000, 1'b0, 2'b01, 32'h0,         8'd1};
    tbl[4]  = '{32'h9000_0000, 2'b00, 4'b0000, 1'b1, 2'b01, 32'h0,         8'd1};
    tbl[5]  = '{32'h9000_0000, 2'b01, 4'b0000, 1'b1, 2'b00, 32'h0,         8'd1};
    tbl[6]  = '{32'h8000_0000, 2'b10, 4'b0000, 1'b1, 2'b00, 32'h0,         8'd1};
    tbl[7]  = '{32'h8000_0000, 2'b10, 4'b0000, 1'b0, 2'b01, 32'h0,         8'd2};
    tbl[8]  = '{32'h8000_0000, 2'b10, 4'b0000, 1'b1, 2'b01, 32'h0,         8'd2};
    tbl[9]  = '{32'h3000_0000, 2'b00, 4'b1000, 1'b0, 2'b01, 32'h0,         8'd3};
    tbl[10] = '{32'h3000_0000, 2'b10, 4'b1000, 1'b1, 2'b01, 32'h0,         8'd3};
    tbl[11] = '{32'h0000_0000, 2'b00, 4'b0001, 1'b1, 2'b00, 32'hA5A5_0003, 8'd3};

    for (int i = 0; i < 4; i++) HRDATA_S[32*i +: 32] = 32'hA5A5_0000 | 32'(i);

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    check_reset_outputs("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_reset();

    // Directed table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].addr, tbl[i].trans);
      chk($sformatf("tbl%0d HSEL", i),    32'(HSEL),    32'(tbl[i].hsel));
      chk($sformatf("tbl%0d HREADY", i),  32'(HREADY),  32'(tbl[i].rdy));
      chk($sformatf("tbl%0d HRESP", i),   32'(HRESP),   32'(tbl[i].resp));
      chk($sformatf("tbl%0d HRDATA", i),  HRDATA,       tbl[i].data);
      chk($sformatf("tbl%0d ERR_CNT", i), 32'(ERR_CNT), 32'(tbl[i].cnt));
      tick();
    end

    // Slave 2 wait states while the master already presents the next address
    HREADYOUT_S = 4'b1011;
    drive(32'h2000_0000, 2'b10);
    check_model("wait addr");
    tick();
    lows = 0;
    for (int k = 0; k < 6; k++) begin
      HRDATA_S[95:64] = $urandom;
      HRDATA_S[31:0]  = $urandom;
      if (k == 3) HREADYOUT_S[2] = 1'b1;
      drive(32'h0000_0000, 2'b10);
      check_model($sformatf("wait%0d", k));
      if (k <= 3) chk("wait data tracks slave2", HRDATA, HRDATA_S[95:64]);
      if (k == 4) chk("wait then slave0", HRDATA, HRDATA_S[31:0]);
      if (!HREADY) lows++;
      tick();
    end
    chk("wait low cycles", 32'(lows), 32'd3);

    // Back-to-back default-slave errors until the counter saturates
    HREADYOUT_S = 4'hF;
    for (int k = 0; k < 600; k++) begin
      drive(32'h8000_0000, 2'b10);
      check_model("sat");
      tick();
    end
    drive(32'h0000_0000, 2'b00);
    check_model("sat end");
    chk("sat ERR_CNT", 32'(ERR_CNT), 32'd255);
    tick();
    tick();

    // Asynchronous reset in the middle of DS_ERR1
    drive(32'h7000_0000, 2'b10);
    tick();
    drive(32'h7000_0000, 2'b00);
    check_model("pre-rst err1");
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("rst err1");
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Asynchronous reset in the middle of a slave wait state
    HREADYOUT_S = 4'b1101;
    drive(32'h1000_0000, 2'b10);
    check_model("pre-rst wait addr");
    tick();
    drive(32'h1000_0000, 2'b00);
    check_model("pre-rst wait");
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("rst wait");
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Normal transfer to slave 3 after reset
    HREADYOUT_S = 4'hF;
    drive(32'h3000_0000, 2'b10);
    check_model("post-rst addr");
    tick();
    drive(32'h0000_0000, 2'b00);
    check_model("post-rst data");
    chk("post-rst slave3 data", HRDATA, HRDATA_S[127:96]);
    tick();

    // Randomized traffic against the reference model
    for (int k = 0; k < 1500; k++) begin
      HRDATA_S = {$urandom, $urandom, $urandom, $urandom};
      for (int s = 0; s < 4; s++) begin
        HREADYOUT_S[s]      = ($urandom_range(0, 3) != 0);
        HRESP_S[2*s +: 2]   = {1'b0, 1'($urandom_range(0, 1))};
      end
      drive({4'($urandom_range(0, 15)), 28'($urandom)}, 2'($urandom_range(0, 3)));
      check_model("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
